// File: rtl/inv_factorial_blk_if.sv
// Request/result bundle for inv_factorial_blk; out_ovf exists only when
// INV_FACTORIAL_OVF_EN is defined. dbg_state mirrors the FSM state.
interface inv_factorial_blk_if;
  logic [45:0] in_data;
  logic        in_valid;
  logic [3:0]  out_data;
  logic        out_exact;
  logic        out_valid;
  logic        out_busy;
`ifdef INV_FACTORIAL_OVF_EN
  logic        out_ovf;
`endif
  logic [1:0]  dbg_state;

  // Handshake: a request is taken on a rising edge where in_valid=1 and the
  // block is idle; the result is valid while out_valid=1 and holds until the
  // next accepted request, which clears it on the accepting edge.
`ifdef INV_FACTORIAL_OVF_EN
  modport master (output in_data, in_valid,
                  input  out_data, out_exact, out_valid, out_busy, out_ovf, dbg_state);
  modport slave  (input  in_data, in_valid,
                  output out_data, out_exact, out_valid, out_busy, out_ovf, dbg_state);
`else
  modport master (output in_data, in_valid,
                  input  out_data, out_exact, out_valid, out_busy, dbg_state);
  modport slave  (input  in_data, in_valid,
                  output out_data, out_exact, out_valid, out_busy, dbg_state);
`endif
endinterface

// File: rtl/inv_factorial_blk.sv
// Inverse factorial: finds the largest n <= MAX_N with n! <= T, one multiply
// per cycle. Optional overflow flag under INV_FACTORIAL_OVF_EN.
module inv_factorial_blk #(
  parameter int MAX_N = 15
) (
  input logic                 clk,
  input logic                 reset,
  inv_factorial_blk_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] MAX_I = 4'(MAX_N);

  state_t      state, state_nxt;
  logic [45:0] target;
  logic [45:0] prod;
  logic [3:0]  n;
  logic [3:0]  i;
  logic [49:0] cand;
  logic        cand_le;
  logic        at_cap;

  logic [3:0]  data_q;
  logic        exact_q;
  logic        valid_q;
  logic        busy_q;

  // prod <= T < 2^46 and i <= 15, so the product always fits in 50 bits
  assign cand    = 50'(prod) * 50'(i);
  assign cand_le = (cand <= {4'b0, target});
  assign at_cap  = (i == MAX_I);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SEARCH;
      SEARCH:  if (!cand_le || at_cap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target  <= '0;
      prod    <= 46'd1;
      n       <= '0;
      i       <= 4'd1;
      data_q  <= '0;
      exact_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            target  <= bus.in_data;
            prod    <= 46'd1;
            n       <= '0;
            i       <= 4'd1;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        SEARCH: begin
          if (cand_le) begin
            prod <= cand[45:0];
            n    <= i;
            i    <= i + 4'd1;
          end
        end
        DONE: begin
          data_q  <= n;
          exact_q <= (prod == target);
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef INV_FACTORIAL_OVF_EN
  logic capped;
  logic ovf_q;

  // capped remembers that the search stopped on the MAX_N limit, not on cand > T
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capped <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            capped <= 1'b0;
            ovf_q  <= 1'b0;
          end
        end
        SEARCH: if (cand_le && at_cap) capped <= 1'b1;
        DONE:   ovf_q <= capped && ((50'(prod) * 50'(MAX_N + 1)) <= {4'b0, target});
        default: ;
      endcase
    end
  end

  assign bus.out_ovf = ovf_q;
`endif

  assign bus.out_data  = data_q;
  assign bus.out_exact = exact_q;
  assign bus.out_valid = valid_q;
  assign bus.out_busy  = busy_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_inv_factorial_blk.sv
// Self-checking bench for inv_factorial_blk: directed table, corner sequences
// and random targets checked against a factorial-table reference model.
module tb_inv_factorial_blk;

  localparam int MAX_N = 15;
  localparam int W     = 12;  // {ovf, exact, n[3:0], lat[5:0]}

  logic clk;
  logic reset;
  inv_factorial_blk_if bus ();

  inv_factorial_blk #(.MAX_N(MAX_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]     exp_q[$];
  int               n_checks = 0;
  int               n_fails  = 0;
  longint unsigned  fact[0:16];

  typedef struct {
    logic [45:0] t;
    logic [3:0]  n;
    logic        exact;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [3:0] n, input logic exact,
                                        input logic ovf, input int lat);
    return {ovf, exact, n, 6'(lat)};
  endfunction

  // Reference: n is the largest k in 1..MAX_N with k! <= T (0 if none)
  function automatic logic [W-1:0] model(input logic [45:0] t);
    int n = 0;
    logic exact, ovf;
    for (int k = 1; k <= MAX_N; k++)
      if (fact[k] <= 64'(t)) n = k;
    exact = (fact[n] == 64'(t));
    ovf   = (n == MAX_N) && (fact[MAX_N + 1] <= 64'(t));
    return pack(4'(n), exact, ovf, (n == MAX_N) ? MAX_N + 1 : n + 2);
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; the request is taken on the next edge.
  task automatic issue(input logic [45:0] t, input logic [W-1:0] exp);
    bus.in_data  = t;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("accept_busy", 64'(bus.out_busy), 1);
    check("accept_valid_clr", 64'(bus.out_valid), 0);
  endtask

  task automatic collect(input int elapsed);
    logic [W-1:0] e;
    int cyc;
    bit got;
    got = 0;
    cyc = elapsed;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    while (!got && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      check("busy_valid_excl", 64'(bus.out_busy & bus.out_valid), 0);
      if (bus.out_valid) got = 1;
    end
    if (!got) begin
      check("result_timeout", 0, 1);
    end else begin
      check("latency", 64'(cyc), 64'(e[5:0]));
      check("out_data", 64'(bus.out_data), 64'(e[9:6]));
      check("out_exact", 64'(bus.out_exact), 64'(e[10]));
      check("done_busy", 64'(bus.out_busy), 0);
`ifdef INV_FACTORIAL_OVF_EN
      check("out_ovf", 64'(bus.out_ovf), 64'(e[11]));
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t vecs[$];
    logic [45:0] t;
    logic [63:0] r;
    logic [3:0]  last_n;

    fact[0] = 1;
    for (int k = 1; k <= 16; k++) fact[k] = fact[k-1] * longint'(k);

    vecs.push_back('{46'd120,           4'd5,  1'b1, 1'b0, 7});
    vecs.push_back('{46'd121,           4'd5,  1'b0, 1'b0, 7});
    vecs.push_back('{46'd0,             4'd0,  1'b0, 1'b0, 2});
    vecs.push_back('{46'd1,             4'd1,  1'b1, 1'b0, 3});
    vecs.push_back('{46'd1307674368000, 4'd15, 1'b1, 1'b0, 16});
    vecs.push_back('{46'h3FFFFFFFFFFF,  4'd15, 1'b0, 1'b1, 16});
    vecs.push_back('{46'd2,             4'd2,  1'b1, 1'b0, 4});
    vecs.push_back('{46'd719,           4'd5,  1'b0, 1'b0, 7});
    vecs.push_back('{46'd720,           4'd6,  1'b1, 1'b0, 8});
    vecs.push_back('{46'd1307674367999, 4'd14, 1'b0, 1'b0, 16});

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_valid", 64'(bus.out_valid), 0);
    check("rst_busy",  64'(bus.out_busy), 0);
    check("rst_data",  64'(bus.out_data), 0);
    check("rst_exact", 64'(bus.out_exact), 0);
`ifdef INV_FACTORIAL_OVF_EN
    check("rst_ovf", 64'(bus.out_ovf), 0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Table, back-to-back: each request is presented while out_valid is high
    foreach (vecs[k]) begin
      issue(vecs[k].t, pack(vecs[k].n, vecs[k].exact, vecs[k].ovf, vecs[k].lat));
      collect(0);
    end
    last_n = vecs[vecs.size()-1].n;

    // Results hold while idle
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", 64'(bus.out_valid), 1);
    check("hold_data",  64'(bus.out_data), 64'(last_n));

    // Requests during a search are ignored
    issue(46'd720, pack(4'd6, 1'b1, 1'b0, 8));
    bus.in_data  = 46'd24;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("ignore_busy", 64'(bus.out_busy), 1);
    end
    bus.in_valid = 1'b0;
    collect(3);
    repeat (2) @(posedge clk);
    #1;
    check("ignore_no_restart", 64'(bus.out_busy), 0);

    // Reset in the middle of a search
    issue(46'd5040, pack(4'd7, 1'b1, 1'b0, 9));
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 0);
    check("midrst_busy",  64'(bus.out_busy), 0);
    check("midrst_data",  64'(bus.out_data), 0);
    check("midrst_exact", 64'(bus.out_exact), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("midrst_no_valid", 64'(bus.out_valid | bus.out_busy), 0);
    end
    issue(46'd2, pack(4'd2, 1'b1, 1'b0, 4));
    collect(0);

    // Random targets against the reference model
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 2))
        0: begin
          r = fact[$urandom_range(0, 16)] + 64'($urandom_range(0, 2));
          t = (r == 0) ? 46'd0 : 46'(r - 1);
        end
        1: begin
          r = {$urandom, $urandom};
          t = 46'(r >> $urandom_range(18, 63));
        end
        default: t = 46'($urandom_range(0, 50000));
      endcase
      issue(t, model(t));
      collect(0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
